// File: rtl/mtimer_pkg.sv
// Shared definitions for the avl_multi_timer register map.
// Optional capture logic elsewhere is enabled with MTIMER_CAPTURE_EN.
package mtimer_pkg;

  typedef logic [2:0] reg_sel_t;

  localparam reg_sel_t REG_STATUS  = 3'd0;
  localparam reg_sel_t REG_CONTROL = 3'd1;
  localparam reg_sel_t REG_PERIOD  = 3'd2;
  localparam reg_sel_t REG_COMPARE = 3'd3;
  localparam reg_sel_t REG_SNAP    = 3'd4;
  localparam reg_sel_t REG_PRESC   = 3'd5;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;
  localparam int ST_CAP = 2;

  localparam int CT_ITO    = 0;
  localparam int CT_CONT   = 1;
  localparam int CT_START  = 2;
  localparam int CT_STOP   = 3;
  localparam int CT_PWM_EN = 4;
  localparam int CT_ICAP   = 5;

endpackage

// File: rtl/mtimer_channel.sv
// One timer channel: down-counter, period/compare/snapshot registers, PWM.
// Input capture (cap_in, STATUS.CAP, CONTROL.ICAP) exists only with MTIMER_CAPTURE_EN.
module mtimer_channel
  import mtimer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 4999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        wr_en,
  input  reg_sel_t    reg_sel,
  input  logic [31:0] wdata,
`ifdef MTIMER_CAPTURE_EN
  input  logic        cap_in,
`endif
  output logic [31:0] rd_data,
  output logic        irq,
  output logic        pwm
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] period_reg, compare_reg, snap_reg, snap_next;
  logic             to_reg, to_next, run_reg, run_next;
  logic             ito_reg, cont_reg, pwm_en_reg, pwm_reg;
  logic             wr_status, wr_control, wr_period, wr_compare, wr_snap;
  logic             start, stop, expire;
  logic             cap_flag, icap_flag, cap_rise;

  assign wr_status  = wr_en && (reg_sel == REG_STATUS);
  assign wr_control = wr_en && (reg_sel == REG_CONTROL);
  assign wr_period  = wr_en && (reg_sel == REG_PERIOD);
  assign wr_compare = wr_en && (reg_sel == REG_COMPARE);
  assign wr_snap    = wr_en && (reg_sel == REG_SNAP);
  assign start      = wr_control && wdata[CT_START];
  assign stop       = wr_control && wdata[CT_STOP];
  assign expire     = tick && run_reg && (count_reg == '0);

`ifdef MTIMER_CAPTURE_EN
  logic [2:0] cap_sync_reg;
  logic       cap_rise_reg, cap_reg, icap_reg;

  // Two synchroniser flops, one history flop, then a registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_sync_reg <= '0;
      cap_rise_reg <= 1'b0;
      cap_reg      <= 1'b0;
      icap_reg     <= 1'b0;
    end else begin
      cap_sync_reg <= {cap_sync_reg[1:0], cap_in};
      cap_rise_reg <= cap_sync_reg[1] & ~cap_sync_reg[2];
      if (wr_status)
        cap_reg <= 1'b0;
      else if (cap_rise_reg)
        cap_reg <= 1'b1;
      if (wr_control)
        icap_reg <= wdata[CT_ICAP];
    end
  end

  assign cap_flag  = cap_reg;
  assign icap_flag = icap_reg;
  assign cap_rise  = cap_rise_reg;
`else
  assign cap_flag  = 1'b0;
  assign icap_flag = 1'b0;
  assign cap_rise  = 1'b0;
`endif

  always_comb begin
    count_next = count_reg;
    run_next   = run_reg;
    to_next    = to_reg;
    snap_next  = snap_reg;
    if (tick && run_reg)
      count_next = (count_reg == '0) ? period_reg : count_reg - 1'b1;
    if (expire) begin
      to_next  = 1'b1;
      run_next = cont_reg;
    end
    if (start)
      run_next = 1'b1;
    else if (stop)
      run_next = 1'b0;
    // A new period takes effect immediately and parks the channel.
    if (wr_period) begin
      count_next = wdata[CNT_W-1:0];
      run_next   = 1'b0;
    end
    if (wr_status)
      to_next = 1'b0;
    if (wr_snap || cap_rise)
      snap_next = count_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= DEF_VAL;
      period_reg  <= DEF_VAL;
      compare_reg <= '0;
      snap_reg    <= '0;
      to_reg      <= 1'b0;
      run_reg     <= 1'b0;
      ito_reg     <= 1'b0;
      cont_reg    <= 1'b0;
      pwm_en_reg  <= 1'b0;
      pwm_reg     <= 1'b0;
    end else begin
      count_reg <= count_next;
      run_reg   <= run_next;
      to_reg    <= to_next;
      snap_reg  <= snap_next;
      if (wr_period)
        period_reg <= wdata[CNT_W-1:0];
      if (wr_compare)
        compare_reg <= wdata[CNT_W-1:0];
      if (wr_control) begin
        ito_reg    <= wdata[CT_ITO];
        cont_reg   <= wdata[CT_CONT];
        pwm_en_reg <= wdata[CT_PWM_EN];
      end
      pwm_reg <= run_reg && pwm_en_reg && (count_reg < compare_reg);
    end
  end

  assign irq = (to_reg && ito_reg) || (cap_flag && icap_flag);
  assign pwm = pwm_reg;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[ST_TO]  = to_reg;
        rd_data[ST_RUN] = run_reg;
        rd_data[ST_CAP] = cap_flag;
      end
      REG_CONTROL: begin
        rd_data[CT_ITO]    = ito_reg;
        rd_data[CT_CONT]   = cont_reg;
        rd_data[CT_PWM_EN] = pwm_en_reg;
        rd_data[CT_ICAP]   = icap_flag;
      end
      REG_PERIOD:  rd_data = 32'(period_reg);
      REG_COMPARE: rd_data = 32'(compare_reg);
      REG_SNAP:    rd_data = 32'(snap_reg);
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/avl_multi_timer.sv
// N-channel Avalon-MM interval timer: address decode, shared prescaler, read mux, IRQ OR.
// Define MTIMER_CAPTURE_EN to add the cap_in capture inputs.
module avl_multi_timer
  import mtimer_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 16,
  parameter int DEF_PERIOD = 4999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(N_CH)+2:0]  address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     irq,
  output logic [N_CH-1:0]          irq_vec,
`ifdef MTIMER_CAPTURE_EN
  input  logic [N_CH-1:0]          cap_in,
`endif
  output logic [N_CH-1:0]          pwm_out
);

  localparam int ADDR_W = $clog2(N_CH) + 3;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0]  ch_sel;
  reg_sel_t         reg_sel;
  logic             wr;
  logic [N_CH-1:0]  ch_hit;
  logic [31:0]      ch_rd [N_CH];
  logic [31:0]      rd_next;
  logic [PRE_W-1:0] presc_reg, pre_cnt_reg;
  logic             tick, wr_presc;

  generate
    if (N_CH > 1) begin : g_sel
      assign ch_sel = address[ADDR_W-1:3];
    end else begin : g_sel_single
      assign ch_sel = '0;
    end
  endgenerate

  assign reg_sel  = address[2:0];
  assign wr       = chipselect && !write_n;
  assign wr_presc = wr && (|ch_hit) && (reg_sel == REG_PRESC);
  assign tick     = (pre_cnt_reg == presc_reg);

  // Shared prescaler; a PRESC write restarts its phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg   <= '0;
      pre_cnt_reg <= '0;
    end else if (wr_presc) begin
      presc_reg   <= writedata[PRE_W-1:0];
      pre_cnt_reg <= '0;
    end else if (tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_hit[gi] = (ch_sel == CH_W'(gi));

      mtimer_channel #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .wr_en   (wr && ch_hit[gi]),
        .reg_sel (reg_sel),
        .wdata   (writedata),
`ifdef MTIMER_CAPTURE_EN
        .cap_in  (cap_in[gi]),
`endif
        .rd_data (ch_rd[gi]),
        .irq     (irq_vec[gi]),
        .pwm     (pwm_out[gi])
      );
    end
  endgenerate

  assign irq = |irq_vec;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++)
      if (ch_hit[i])
        rd_next = ch_rd[i];
    if ((|ch_hit) && (reg_sel == REG_PRESC))
      rd_next = 32'(presc_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

endmodule

// File: doc/avl_multi_timer.md
Name: avl_multi_timer

Overview:
- N-channel Avalon-MM interval timer; successor to the single-channel 16-bit-bus timer.
- Each channel has:
  - a CNT_W-bit down-counter with one-shot or continuous mode;
  - a compare register driving a PWM output;
  - a snapshot register.
- All channels share one prescaler.
- Sits on the CPU peripheral bus, 32-bit data; one combined IRQ to the interrupt controller plus a per-channel IRQ vector.

Parameters:
- N_CH, 4, number of channels (1..8).
- CNT_W, 32, counter/period/compare width (8..32).
- PRE_W, 16, prescaler divider width.
- DEF_PERIOD, 4999, reset value of every PERIOD register.

Ports:
- clk  in  1  clock
- reset_n  in  1  async reset, active-low
- address  in  $clog2(N_CH)+3  {channel, reg[2:0]}
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  OR of all channel interrupts
- irq_vec  out  N_CH  per-channel interrupt
- pwm_out  out  N_CH  registered PWM outputs
- cap_in  in  N_CH  capture inputs; present only with MTIMER_CAPTURE_EN

Behaviour:
- Reset: clk is the clock; reset_n is asynchronous, active-low.
  - readdata=0, irq=0, irq_vec=0, pwm_out=0.
  - Counters=DEF_PERIOD, PERIOD=DEF_PERIOD, COMPARE=0, CONTROL=0, SNAP=0, PRESC=0, all channels stopped.
- Register map per channel:
  - reg0 STATUS: [0] TO, [1] RUN. Any write clears TO.
  - reg1 CONTROL: [0] ITO, [1] CONT, [4] PWM_EN stored. [2] START, [3] STOP are write-only strobes and read 0.
  - reg2 PERIOD (CNT_W, zero-extended on read).
  - reg3 COMPARE.
  - reg4 SNAP: a write copies the live counter; a read returns the copy.
  - reg5 PRESC: global divider; writes via any channel address, same value reads from every channel.
  - reg6/7 read 0, writes ignored.
  - Channel index >= N_CH reads 0.
- Read latency: exactly 1 clk; readdata registered every cycle from the current address.
- Prescaler: free-running counter; tick asserted 1 clk when it equals PRESC, then wraps to 0. PRESC=0 gives a tick every clk. A PRESC write resets the prescaler counter to 0.
- Channel counter, on tick while RUN:
  - count==0: reload PERIOD, TO<=1 (edge; no re-fire while held at 0), RUN<=CONT.
  - otherwise: count<=count-1.
- Timeout period = (PERIOD+1)*(PRESC+1) clk.
- Stopped channels hold count.
- PERIOD write: counter reloads with the new value next clk and RUN<=0; software must START again.
- START and STOP in the same write: START wins. START while running: no effect on count.
- Simultaneous TO set and STATUS write: clear wins; the event is lost, as documented.
- irq_vec[i]=TO[i]&ITO[i]; irq=|irq_vec; both combinational from registers.
- pwm_out[i] registered: RUN & PWM_EN & (count < COMPARE).
  - COMPARE=0 gives constant 0.
  - COMPARE>PERIOD gives constant 1 while running.
- Widths: writedata truncated to CNT_W/PRE_W; no saturation; decrement never wraps because zero reloads.

Optional Feature:
- Macro MTIMER_CAPTURE_EN.
- Defined:
  - cap_in port exists; each bit passes through a 2-flop synchroniser plus edge detect.
  - A rising edge copies the counter into SNAP and sets STATUS[2] CAP.
  - CONTROL[5] ICAP adds CAP&ICAP to irq_vec.
  - A STATUS write clears CAP.
  - Capture and a software SNAP write in the same clk: capture wins.
- Undefined: no cap_in port; STATUS[2] and CONTROL[5] read 0.

Decomposition:
- Package mtimer_pkg:
  - register offsets REG_STATUS..REG_PRESC;
  - CONTROL/STATUS bit index constants;
  - a typedef for the 3-bit register select.
- Sub-module mtimer_channel:
  - holds counter, PERIOD, COMPARE, CONTROL, SNAP, TO, RUN, PWM and capture logic;
  - instantiated N_CH times by generate.
- The top holds address decode, prescaler, read mux and IRQ OR.

Test Plan:
- Reset, read every register of ch0 -> PERIOD=4999, others 0; readdata valid exactly 1 clk after the address is presented.
- PRESC=0, ch1 PERIOD=4, CONTROL=START|CONT|ITO -> TO/irq_vec[1] rises every 5 clk; a STATUS write drops irq next clk; the channel keeps running.
- PRESC=3, ch0 PERIOD=2, START without CONT -> single TO after 12 clk, RUN=0, count parked at 2.
- ch2 PERIOD=9, COMPARE=3, PWM_EN|START|CONT, PRESC=0 -> pwm_out[2] high 3 of every 10 clk; COMPARE=0 -> constant low.
- Running ch3: write PERIOD=100 -> RUN=0 next clk; SNAP write then read returns 100. Same-clk STATUS clear and timeout -> TO stays 0.
- With MTIMER_CAPTURE_EN: cap_in[0] pulse at count 37 -> SNAP equals count at synchroniser exit (37 minus 3 at PRESC=0); CAP=1; irq when ICAP=1.
